// File: rtl/br_gen_prog.sv
// Programmable baud-rate generator: loadable clock divisor -> oversample tick, OVS ticks -> bit tick.
// Optional fractional divisor is compiled in with `define BRG_FRAC_EN.
module br_gen_prog #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OVS     = 16,
  parameter int DEF_DIV = 1,
  parameter int SYNC_PH = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ce_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              load_i,
  input  logic              sync_i,
  output logic              ovs_o,
  output logic              baud_o
);

  localparam int PH_W = (OVS > 2) ? $clog2(OVS) : 1;

  logic [DIV_W-1:0] div_q, div_nxt, cnt_q, cnt_d, reload;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             ovs_q, ovs_d, baud_q, baud_d;

  // A divisor loaded this cycle already governs a reload happening this cycle.
  assign div_nxt = load_i ? ((div_i == '0) ? DIV_W'(1) : div_i) : div_q;

`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_nxt, acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  assign frac_nxt = load_i ? frac_i : frac_q;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_nxt};
  // Carry out of the accumulator stretches the next period by one clock.
  assign reload   = acc_sum[FRAC_W] ? div_nxt : div_nxt - DIV_W'(1);
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
  assign reload      = div_nxt - DIV_W'(1);
`endif

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    ovs_d   = 1'b0;
    baud_d  = 1'b0;
`ifdef BRG_FRAC_EN
    acc_d   = acc_q;
`endif
    if (sync_i) begin
      cnt_d   = div_nxt - DIV_W'(1);
      phase_d = PH_W'(SYNC_PH);
`ifdef BRG_FRAC_EN
      acc_d   = '0;
`endif
    end else if (ce_i) begin
      if (cnt_q == '0) begin
        ovs_d = 1'b1;
        cnt_d = reload;
`ifdef BRG_FRAC_EN
        acc_d = acc_sum[FRAC_W-1:0];
`endif
        if (phase_q == PH_W'(OVS - 1)) begin
          phase_d = '0;
          baud_d  = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= DIV_W'(DEF_DIV);
      cnt_q   <= DIV_W'(DEF_DIV - 1);
      phase_q <= '0;
      ovs_q   <= 1'b0;
      baud_q  <= 1'b0;
`ifdef BRG_FRAC_EN
      frac_q  <= '0;
      acc_q   <= '0;
`endif
    end else begin
      div_q   <= div_nxt;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ovs_q   <= ovs_d;
      baud_q  <= baud_d;
`ifdef BRG_FRAC_EN
      frac_q  <= frac_nxt;
      acc_q   <= acc_d;
`endif
    end
  end

  assign ovs_o  = ovs_q;
  assign baud_o = baud_q;

endmodule

// File: tb/tb_br_gen_prog.sv
// Directed bench for br_gen_prog: tick gaps, baud spacing, load/sync/ce/reset behaviour.
module tb_br_gen_prog;
  localparam int DIV_W = 16, FRAC_W = 4, OVS = 16, DEF_DIV = 4, SYNC_PH = 8;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1, ce_i = 1'b1, load_i = 1'b0, sync_i = 1'b0;
  logic [DIV_W-1:0]  div_i = '0;
  logic [FRAC_W-1:0] frac_i = '0;
  logic              ovs_o, baud_o;
  int                n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  br_gen_prog #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_DIV(DEF_DIV), .SYNC_PH(SYNC_PH)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .ce_i(ce_i), .div_i(div_i), .frac_i(frac_i),
    .load_i(load_i), .sync_i(sync_i), .ovs_o(ovs_o), .baud_o(baud_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Cycles until the next ovs_o pulse; -1 if none within the budget.
  task automatic wait_ovs(output int n);
    n = 0;
    do begin tick(); n++; end while (!ovs_o && n < 200);
    if (!ovs_o) n = -1;
  endtask

  // Count ovs/baud pulses over nc cycles; fb = cycle index of first baud.
  // A baud without a coincident ovs inflates nb so the caller's check trips.
  task automatic run(input int nc, output int novs, output int fb, output int nb);
    novs = 0; fb = 0; nb = 0;
    for (int i = 1; i <= nc; i++) begin
      tick();
      if (ovs_o) novs++;
      if (baud_o) begin
        nb++;
        if (fb == 0) fb = i;
        if (!ovs_o) nb += 100;
      end
    end
  endtask

  task automatic rst_load(input int d, input int f);
    reset_i = 1'b1; load_i = 1'b0; sync_i = 1'b0; ce_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0; load_i = 1'b1; div_i = DIV_W'(d); frac_i = FRAC_W'(f);
    tick();
    load_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, novs, fb, nb, sum;
    // reset state and default divisor
    tick(); tick();
    chk("rst_ovs", ovs_o, 0);
    chk("rst_baud", baud_o, 0);
    reset_i = 1'b0;
    wait_ovs(n);      chk("first_ovs", n, DEF_DIV);
    run(60, novs, fb, nb);
    chk("def_novs", novs, 15); chk("def_baud_at", fb, 60); chk("def_nbaud", nb, 1);
    wait_ovs(n);      chk("def_gap", n, 4);
    run(60, novs, fb, nb);
    chk("def_baud2_at", fb, 60); chk("def_nbaud2", nb, 1);

    // div 0 treated as 1
    rst_load(0, 0);
    wait_ovs(n);      chk("div0_first", n, 3);
    run(32, novs, fb, nb);
    chk("div0_novs", novs, 32); chk("div0_nbaud", nb, 2); chk("div0_baud_at", fb, 15);

    // ce_i stall mid-period
    rst_load(10, 0);
    wait_ovs(n);      chk("div10_first", n, 3);
    wait_ovs(n);      chk("div10_gap", n, 10);
    run(4, novs, fb, nb); chk("ce_pre", novs, 0);
    ce_i = 1'b0;
    run(3, novs, fb, nb); chk("ce_hold", novs, 0);
    ce_i = 1'b1;
    wait_ovs(n);      chk("ce_gap", 7 + n, 13);

    // load mid-period
    rst_load(5, 0);
    wait_ovs(n);
    wait_ovs(n);      chk("div5_gap", n, 5);
    run(2, novs, fb, nb);
    load_i = 1'b1; div_i = DIV_W'(3);
    tick();
    load_i = 1'b0;
    wait_ovs(n);      chk("ld_cur_gap", 3 + n, 5);
    wait_ovs(n);      chk("ld_new_gap1", n, 3);
    wait_ovs(n);      chk("ld_new_gap2", n, 3);

    // sync with cnt==0 pending
    rst_load(2, 0);
    wait_ovs(n);
    wait_ovs(n);      chk("div2_gap", n, 2);
    run(1, novs, fb, nb);
    sync_i = 1'b1;
    tick();
    chk("sync_nopulse", ovs_o, 0);
    sync_i = 1'b0;
    run(16, novs, fb, nb);
    chk("sync_novs", novs, 8); chk("sync_baud_at", fb, 16); chk("sync_nbaud", nb, 1);
    run(32, novs, fb, nb);
    chk("sync_novs2", novs, 16); chk("sync_baud2_at", fb, 32); chk("sync_nbaud2", nb, 1);

    // sync while ce_i low
    ce_i = 1'b0; sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    run(5, novs, fb, nb); chk("sync_ce0_hold", novs, 0);
    ce_i = 1'b1;
    wait_ovs(n);      chk("sync_ce0_gap", n, 2);

    // reset mid-period restores default divisor
    rst_load(10, 0);
    run(5, novs, fb, nb);
    reset_i = 1'b1;
    tick();
    chk("rst_mid_ovs", ovs_o, 0);
    reset_i = 1'b0;
    wait_ovs(n);      chk("rst_mid_gap", n, DEF_DIV);

`ifdef BRG_FRAC_EN
    rst_load(4, 8);
    wait_ovs(n);
    wait_ovs(n);      chk("frac_gap1", n, 4);
    sum = n;
    wait_ovs(n);      chk("frac_gap2", n, 5);
    sum += n;
    for (int k = 0; k < 14; k++) begin
      wait_ovs(n);
      sum += n;
    end
    chk("frac_span16", sum, 72);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
